digit_emit_ctrl: RTL and testbench
==================================

DIGIT_EMIT_CTRL -- requirements
Module: digit_emit_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 8, meaning the number of display digits emitted per value; legal range 1..8.
REQ-002 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, request to emit value; sampled only in IDLE.
REQ-005 SHALL have port clear, input, 1 bit, synchronous abort/acknowledge; returns the FSM to IDLE.
REQ-006 SHALL have port value, input, 27 bits, unsigned binary number to display.
REQ-007 SHALL have port busy, output, 1 bit, high in LOAD, EMIT and ERR.
REQ-008 SHALL have port done, output, 1 bit, one-cycle pulse at end of an emission.
REQ-009 SHALL have port digit_valid, output, 1 bit, data/pos hold a digit this cycle.
REQ-010 SHALL have port data, output, 4 bits, digit code: 0-9, 4'hF blank, 4'hE error.
REQ-011 SHALL have port pos, output, 4 bits, digit position; 0 is least significant.
REQ-012 SHALL have port status, output, 2 bits: 00 error, 01 busy, 10 ready, 11 printing.

Function
REQ-013 SHALL implement states IDLE, LOAD, EMIT, DONE, ERR.
REQ-014 IDLE: start=1 at an edge SHALL latch value into a 27-bit work register and clear the index, then go to LOAD.
REQ-015 LOAD, overflow check: if work > 10^NDIG-1, the FSM SHALL go to ERR; otherwise to EMIT.
REQ-016 EMIT, each cycle: digit_valid=1, pos=index, data=work%10, with index advancing 0..NDIG-1.
REQ-017 EMIT, next-state: work<=work/10 and index<=index+1 at each edge.
REQ-018 EMIT, exit: after index NDIG-1 the FSM SHALL go to DONE.
REQ-019 Leading-zero blanking: in EMIT, when index>0 and work==0, data SHALL be 4'hF; index 0 always shows a numeric digit, so value 0 displays "0".
REQ-020 DONE SHALL last exactly one cycle: done=1, digit_valid=0, then IDLE.
REQ-021 ERR, first NDIG cycles: the block SHALL emit data=4'hE with digit_valid=1 and pos=0..NDIG-1.
REQ-022 ERR, after emission: the block SHALL stay in ERR with digit_valid=0 and status=00 until clear; done SHALL not pulse and start SHALL be ignored.
REQ-023 Latency: start sampled at edge E0 gives LOAD after E0 and EMIT after E1; digits occupy the NDIG cycles after E1..E(NDIG); done is high in the cycle after E(NDIG+1).
REQ-024 start outside IDLE SHALL be ignored; new value SHALL not disturb an emission in progress.
REQ-025 clear=1 in any state SHALL force IDLE at the next edge with no done pulse; clear has priority over start in the same cycle.
REQ-026 status encoding: IDLE/DONE=10, LOAD=01, EMIT=11, ERR=00.
REQ-027 Outside EMIT/ERR emission: digit_valid SHALL be 0, and data/pos SHALL be 0.
REQ-028 Arithmetic SHALL be unsigned 27-bit; /10 and %10 are exact integer results.
REQ-029 Back-to-back operation: start in the IDLE cycle that immediately follows DONE SHALL be accepted.

Reset
REQ-030 reset=1 SHALL asynchronously force IDLE, work=0, index=0, busy=0, done=0, digit_valid=0, data=0, pos=0, status=10.
REQ-031 Reset asserted mid-EMIT or in ERR SHALL abort immediately; no done pulse is produced after release.
REQ-032 After reset deasserts, the first start SHALL be honoured at the first edge.

Verification
REQ-033 Digit order: value=1234, start 1 cycle -> data 4,3,2,1,F,F,F,F at pos 0..7, then one done pulse, status 11 during emission and 10 after.
REQ-034 Zero and max: value=0 -> 0,F,F,F,F,F,F,F; value=99_999_999 -> eight 9s, done after 10 cycles from start edge.
REQ-035 Overflow: value=100_000_000 -> eight 4'hE digits, no done, status 00 held; clear -> status 10 next cycle.
REQ-036 Busy rejection: start pulsed with value=5 during EMIT of 1234 -> ignored, 1234 output intact; start right after done with 5 -> 5,F... emitted.
REQ-037 Aborts: reset asserted at pos=3 -> outputs zero immediately, no done; clear at pos=3 -> IDLE next edge, no done.
REQ-038 Parameter: NDIG=4, value=9999 -> 9,9,9,9 then done; value=10000 -> ERR.

Source files
------------

// File: rtl/digit_emit_ctrl_if.sv
// Handshake/result bundle for digit_emit_ctrl: request side and digit stream side.
interface digit_emit_ctrl_if;
  logic        start;
  logic        clear;
  logic [26:0] value;
  logic        busy;
  logic        done;
  logic        digit_valid;
  logic [3:0]  data;
  logic [3:0]  pos;
  logic [1:0]  status;

  modport master (
    output start, clear, value,
    input  busy, done, digit_valid, data, pos, status
  );

  modport slave (
    input  start, clear, value,
    output busy, done, digit_valid, data, pos, status
  );
endinterface

// File: rtl/digit_emit_ctrl.sv
// Serialises a 27-bit unsigned value into NDIG decimal digits, least significant
// first, with leading-zero blanking and an overflow error display.
module digit_emit_ctrl #(
  parameter int NDIG = 8
) (
  input  logic              clock,
  input  logic              reset,
  digit_emit_ctrl_if.slave  bus
);

  function automatic longint pow10(input int n);
    longint r;
    r = 64'sd1;
    for (int i = 0; i < n; i++) r = r * 64'sd10;
    return r;
  endfunction

  localparam logic [26:0] LIMIT    = 27'(pow10(NDIG) - 64'sd1);
  localparam logic [3:0]  LAST_IDX = 4'(NDIG - 1);
  localparam logic [3:0]  ERR_END  = 4'(NDIG);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EMIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [26:0] work_q,  work_d;
  logic [3:0]  idx_q,   idx_d;

  logic [26:0] work_div_s;
  logic [3:0]  work_mod_s;

  assign work_div_s = work_q / 27'd10;
  assign work_mod_s = 4'(work_q % 27'd10);

  // State, work register and digit index; reset drops everything to IDLE at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= 27'd0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic and outputs decoded from the current state.
  always_comb begin
    state_d         = state_q;
    work_d          = work_q;
    idx_d           = idx_q;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.digit_valid = 1'b0;
    bus.data        = 4'd0;
    bus.pos         = 4'd0;
    bus.status      = 2'b10;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.value;
          idx_d   = 4'd0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        bus.busy   = 1'b1;
        bus.status = 2'b01;
        if (work_q > LIMIT) state_d = ERR;
        else                state_d = EMIT;
      end
      EMIT: begin
        bus.busy        = 1'b1;
        bus.status      = 2'b11;
        bus.digit_valid = 1'b1;
        bus.pos         = idx_q;
        // Index 0 always shows a numeric digit so a zero value reads "0".
        if ((idx_q != 4'd0) && (work_q == 27'd0)) bus.data = 4'hF;
        else                                      bus.data = work_mod_s;
        work_d = work_div_s;
        idx_d  = idx_q + 4'd1;
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   state_d = EMIT;
      end
      DONE: begin
        bus.done = 1'b1;
        idx_d    = 4'd0;
        state_d  = IDLE;
      end
      ERR: begin
        bus.busy   = 1'b1;
        bus.status = 2'b00;
        // Show NDIG error glyphs once, then hold silently until cleared.
        if (idx_q < ERR_END) begin
          bus.digit_valid = 1'b1;
          bus.data        = 4'hE;
          bus.pos         = idx_q;
          idx_d           = idx_q + 4'd1;
        end else begin
          idx_d = idx_q;
        end
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear wins over everything, including a start in the same cycle.
    if (bus.clear) begin
      state_d = IDLE;
      idx_d   = 4'd0;
    end else begin
      state_d = state_d;
    end
  end

endmodule

// File: tb/tb_digit_emit_ctrl.sv
// Directed self-checking bench for digit_emit_ctrl (NDIG=8 and NDIG=4 instances).
module tb_digit_emit_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [26:0] value = 27'd0;
  logic        sel   = 1'b0;   // 0: observe NDIG=8 instance, 1: NDIG=4 instance

  int n_cmp = 0;
  int n_err = 0;

  digit_emit_ctrl_if if8 ();
  digit_emit_ctrl_if if4 ();

  assign if8.start = start;
  assign if8.clear = clear;
  assign if8.value = value;
  assign if4.start = start;
  assign if4.clear = clear;
  assign if4.value = value;

  digit_emit_ctrl #(.NDIG(8)) u_dut8 (.clock(clock), .reset(reset), .bus(if8.slave));
  digit_emit_ctrl #(.NDIG(4)) u_dut4 (.clock(clock), .reset(reset), .bus(if4.slave));

  logic       o_busy, o_done, o_valid;
  logic [3:0] o_data, o_pos;
  logic [1:0] o_status;

  assign o_busy   = sel ? if4.busy        : if8.busy;
  assign o_done   = sel ? if4.done        : if8.done;
  assign o_valid  = sel ? if4.digit_valid : if8.digit_valid;
  assign o_data   = sel ? if4.data        : if8.data;
  assign o_pos    = sel ? if4.pos         : if8.pos;
  assign o_status = sel ? if4.status      : if8.status;

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Outputs expected in IDLE (or just after an abort).
  task automatic check_idle(input string tag);
    check_eq({tag, ".status"}, 32'(o_status), 32'h2);
    check_eq({tag, ".busy"},   32'(o_busy),   32'h0);
    check_eq({tag, ".done"},   32'(o_done),   32'h0);
    check_eq({tag, ".valid"},  32'(o_valid),  32'h0);
    check_eq({tag, ".data"},   32'(o_data),   32'h0);
    check_eq({tag, ".pos"},    32'(o_pos),    32'h0);
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE.
  // exp holds the expected digit for position i in nibble i.
  task automatic run(input string tag, input logic [26:0] v, input logic [31:0] exp,
                     input int nd, input bit is_err, input int inject);
    start = 1'b1;
    value = v;
    @(negedge clock);
    start = 1'b0;
    check_eq({tag, ".load_status"}, 32'(o_status), 32'h1);
    check_eq({tag, ".load_busy"},   32'(o_busy),   32'h1);
    check_eq({tag, ".load_valid"},  32'(o_valid),  32'h0);
    for (int i = 0; i < nd; i++) begin
      @(negedge clock);
      start = 1'b0;
      check_eq({tag, ".valid"},  32'(o_valid),  32'h1);
      check_eq({tag, ".pos"},    32'(o_pos),    32'(i));
      check_eq({tag, ".data"},   32'(o_data),   32'((exp >> (4 * i)) & 32'hF));
      check_eq({tag, ".status"}, 32'(o_status), is_err ? 32'h0 : 32'h3);
      check_eq({tag, ".done"},   32'(o_done),   32'h0);
      if (i == inject) begin
        start = 1'b1;
        value = 27'd5;
      end
    end
    start = 1'b0;
    @(negedge clock);
    if (is_err) begin
      for (int k = 0; k < 3; k++) begin
        check_eq({tag, ".err_status"}, 32'(o_status), 32'h0);
        check_eq({tag, ".err_valid"},  32'(o_valid),  32'h0);
        check_eq({tag, ".err_done"},   32'(o_done),   32'h0);
        check_eq({tag, ".err_busy"},   32'(o_busy),   32'h1);
        start = (k == 0);
        @(negedge clock);
      end
      start = 1'b0;
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      check_idle({tag, ".cleared"});
    end else begin
      check_eq({tag, ".done"},        32'(o_done),   32'h1);
      check_eq({tag, ".done_status"}, 32'(o_status), 32'h2);
      check_eq({tag, ".done_valid"},  32'(o_valid),  32'h0);
      check_eq({tag, ".done_busy"},   32'(o_busy),   32'h0);
      @(negedge clock);
      check_idle({tag, ".after"});
    end
  endtask

  initial begin
    // Reset state
    #2;
    check_idle("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_idle("post_reset");
    @(negedge clock);

    run("v1234", 27'd1234,      32'hFFFF1234, 8, 1'b0, -1);
    run("v0",    27'd0,         32'hFFFFFFF0, 8, 1'b0, -1);
    run("vmax",  27'd99999999,  32'h99999999, 8, 1'b0, -1);
    run("ovf",   27'd100000000, 32'hEEEEEEEE, 8, 1'b1, -1);
    run("ovf27", 27'd134217727, 32'hEEEEEEEE, 8, 1'b1, -1);

    // Start during emission is ignored; start right after DONE is taken.
    run("busyrej", 27'd1234, 32'hFFFF1234, 8, 1'b0, 2);
    run("b2b",     27'd5,    32'hFFFFFFF5, 8, 1'b0, -1);
    run("v907",    27'd907,  32'hFFFFF907, 8, 1'b0, -1);

    // Reset at pos 3 aborts at once; first start after release is taken.
    start = 1'b1;
    value = 27'd1234;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clock);
    check_eq("rst_abort.pos_before", 32'(o_pos), 32'h3);
    reset = 1'b1;
    #1;
    check_idle("rst_abort");
    @(negedge clock);
    reset = 1'b0;
    run("after_rst", 27'd42, 32'hFFFFFF42, 8, 1'b0, -1);

    // Clear at pos 3 returns to IDLE at the next edge with no done.
    start = 1'b1;
    value = 27'd1234;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clock);
    check_eq("clr_abort.pos_before", 32'(o_pos), 32'h3);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    start = 1'b0;
    check_idle("clr_abort");
    @(negedge clock);
    check_idle("clr_abort2");

    // NDIG=4 instance
    sel = 1'b1;
    run("n4_9999",  27'd9999,  32'h00009999, 4, 1'b0, -1);
    run("n4_10000", 27'd10000, 32'h0000EEEE, 4, 1'b1, -1);
    run("n4_30",    27'd30,    32'h0000FF30, 4, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
